// File: rtl/mole_field.sv
// mole_field -- whack-a-mole game core.
//
// Lights up to MAX_ACTIVE of N_CH LEDs on request of an external RNG, scores
// switch toggles on lit channels, charges a penalty for toggles on dark
// channels, counts targets that time out, and runs a session of GAME_TICKS
// 1 ms ticks.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   start             one-cycle pulse, begins a session from IDLE or OVER
//   level             00 easy, 01 medium, 1x hard; latched on accepted start
//   spawn_valid/index RNG target offer (index >= N_CH is consumed and dropped)
//   spawn_ready       core can take a target this cycle
//   switches          synchronised slide switches
//   leds              lit targets
//   score             session score, clamped to [0, 2^SCORE_W-1]
//   misses            timed-out targets, saturating at 255
//   game_active       high while playing
//   game_over         high after the session timer expires
module mole_field #(
  parameter int N_CH       = 18,
  parameter int IDX_W      = 5,
  parameter int SCORE_W    = 12,
  parameter int TICK_DIV   = 50000,
  parameter int LIFE_EASY  = 2000,
  parameter int LIFE_MED   = 1000,
  parameter int LIFE_HARD  = 500,
  parameter int MAX_ACTIVE = 3,
  parameter int GAME_TICKS = 60000,
  parameter int PENALTY    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         level,
  input  logic               spawn_valid,
  input  logic [IDX_W-1:0]   spawn_index,
  output logic               spawn_ready,
  input  logic [N_CH-1:0]    switches,
  output logic [N_CH-1:0]    leds,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         misses,
  output logic               game_active,
  output logic               game_over
);

  localparam int LIFE_MAXV = (LIFE_EASY > LIFE_MED)
                           ? ((LIFE_EASY > LIFE_HARD) ? LIFE_EASY : LIFE_HARD)
                           : ((LIFE_MED > LIFE_HARD) ? LIFE_MED : LIFE_HARD);
  localparam int LIFE_W    = $clog2(LIFE_MAXV + 1);
  localparam int GT_W      = $clog2(GAME_TICKS + 1);
  localparam int TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [GT_W-1:0]      game_timer_q, game_timer_d;
  logic [1:0]           level_q, level_d;
  logic [N_CH-1:0]      sw_q, sw_d;
  logic [N_CH-1:0]      leds_q, leds_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic [LIFE_W-1:0]    life_q [N_CH];
  logic [LIFE_W-1:0]    life_d [N_CH];

  logic                 play;
  logic                 tick;
  logic                 start_acc;
  logic                 spawn_fire;
  logic                 game_end;
  logic [N_CH-1:0]      toggle;
  logic [N_CH-1:0]      hit_vec;
  logic [N_CH-1:0]      wrong_vec;
  logic [N_CH-1:0]      timeout_vec;
  logic [N_CH-1:0]      spawn_vec;
  logic [LIFE_W-1:0]    life_load;
  logic [1:0]           points;
  int                   score_calc;
  int                   miss_calc;

  assign play        = (state_q == S_PLAY);
  assign tick        = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign start_acc   = start && !play;
  assign toggle      = switches ^ sw_q;
  assign spawn_ready = play && ($countones(leds_q) < MAX_ACTIVE);
  assign spawn_fire  = spawn_valid && spawn_ready;
  // The final tick ends the session; nothing else that cycle is scored.
  assign game_end    = play && tick && (game_timer_q == GT_W'(1));

  assign life_load = (level_q == 2'b00) ? LIFE_W'(LIFE_EASY) :
                     (level_q == 2'b01) ? LIFE_W'(LIFE_MED)  : LIFE_W'(LIFE_HARD);
  assign points    = (level_q == 2'b00) ? 2'd1 :
                     (level_q == 2'b01) ? 2'd2 : 2'd3;

  // Per-channel event decode and life counter. All decisions use the
  // registered LED state, so a spawn onto a channel being hit or timing out
  // this cycle sees it lit and is dropped, and a hit masks a timeout.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign hit_vec[gi]     = play & toggle[gi] & leds_q[gi];
      assign wrong_vec[gi]   = play & toggle[gi] & ~leds_q[gi];
      assign timeout_vec[gi] = play & tick & leds_q[gi] & ~toggle[gi] &
                               (life_q[gi] == LIFE_W'(1));
      // Out-of-range indices never match any channel and are simply consumed.
      assign spawn_vec[gi]   = spawn_fire & (spawn_index == IDX_W'(gi)) & ~leds_q[gi];
      assign life_d[gi]      = start_acc     ? '0 :
                               spawn_vec[gi] ? life_load :
                               (play && tick && leds_q[gi] && (life_q[gi] != '0))
                                             ? life_q[gi] - LIFE_W'(1)
                                             : life_q[gi];
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TICK_W'(1);
    game_timer_d = game_timer_q;
    level_d      = level_q;
    sw_d         = switches;
    leds_d       = leds_q;
    score_d      = score_q;
    misses_d     = misses_q;
    score_calc   = int'(score_q) + $countones(hit_vec) * int'(points)
                 - $countones(wrong_vec) * PENALTY;
    miss_calc    = int'(misses_q) + $countones(timeout_vec);

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d      = S_PLAY;
          tick_cnt_d   = '0;
          game_timer_d = GT_W'(GAME_TICKS);
          level_d      = level;
          leds_d       = '0;
          score_d      = '0;
          misses_d     = '0;
        end
      end
      S_PLAY: begin
        if (tick) begin
          game_timer_d = game_timer_q - GT_W'(1);
        end
        if (game_end) begin
          state_d = S_OVER;
          leds_d  = '0;
        end else begin
          leds_d = (leds_q & ~hit_vec & ~timeout_vec) | spawn_vec;
          if (score_calc < 0) begin
            score_d = '0;
          end else if (score_calc > SCORE_MAX) begin
            score_d = SCORE_W'(SCORE_MAX);
          end else begin
            score_d = score_calc[SCORE_W-1:0];
          end
          misses_d = (miss_calc > 255) ? 8'hFF : miss_calc[7:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      game_timer_q <= '0;
      level_q      <= '0;
      sw_q         <= '0;
      leds_q       <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        life_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      game_timer_q <= game_timer_d;
      level_q      <= level_d;
      sw_q         <= sw_d;
      leds_q       <= leds_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      for (int i = 0; i < N_CH; i++) begin
        life_q[i] <= life_d[i];
      end
    end
  end

  assign leds        = leds_q;
  assign score       = score_q;
  assign misses      = misses_q;
  assign game_active = (state_q == S_PLAY);
  assign game_over   = (state_q == S_OVER);

endmodule
